boot_mem_arbiter: RTL and testbench

//  Single-port synchronous program RAM (64x16 by default) with ownership arbitration between the UART

---
 rtl/boot_mem_pkg.sv | 15 +
 rtl/ram_sp_sync.sv | 26 ++
 rtl/boot_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_boot_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_mem_pkg.sv
// Shared definitions for the boot-loader / CPU program RAM arbiter.
package boot_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        LOADER_OWN = 2'd1,
        GUARD      = 2'd2,
        CPU_OWN    = 2'd3
    } state_t;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port RAM: synchronous write, registered read; dout only changes on a read.
module ram_sp_sync #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) mem[adr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              dout <= '0;
        else if (en && !we)   dout <= mem[adr];
    end

endmodule

// File: rtl/boot_mem_arbiter.sv
// Program RAM shared by the UART boot loader and the CPU, cleared after reset,
// with a one-cycle GUARD state separating every ownership handover.
module boot_mem_arbiter
    import boot_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              boot,
    input  logic              ld_enable,
    input  logic              ld_rw,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_in,
    output logic [DATA_W-1:0] ld_out,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_in,
    output logic [DATA_W-1:0] cpu_out,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic              mem_busy,
    output logic              drop_err,
    output logic [ADDR_W:0]   ld_wr_count
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] clr_adr;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    logic              ld_acc, ld_wr, ld_rd, ld_drop, cpu_acc, cpu_rd;
    logic              ld_sel, cpu_sel;
    logic [DATA_W-1:0] ld_hold, cpu_hold;

    assign ld_acc  = ce && (state == LOADER_OWN) && ld_enable;
    assign ld_wr   = ld_acc && ld_rw;
    assign ld_rd   = ld_acc && !ld_rw;
    assign ld_drop = ce && (state != LOADER_OWN) && ld_enable && ld_rw;
    assign cpu_acc = ce && (state == CPU_OWN) && cpu_req;
    assign cpu_rd  = cpu_acc && !cpu_rw;

    assign cpu_wait = cpu_req && (state != CPU_OWN);

    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_adr = '0;
        ram_din = '0;
        unique case (state)
            CLEAR: begin
                ram_en  = ce;
                ram_we  = 1'b1;
                ram_adr = clr_adr;
            end
            LOADER_OWN: begin
                ram_en  = ld_acc;
                ram_we  = ld_rw;
                ram_adr = ld_adr;
                ram_din = ld_in;
            end
            CPU_OWN: begin
                ram_en  = cpu_acc;
                ram_we  = cpu_rw;
                ram_adr = cpu_adr;
                ram_din = cpu_in;
            end
            default: ;
        endcase
    end

    ram_sp_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (ram_we),
        .adr  (ram_adr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_adr  <= '0;
            mem_busy <= 1'b1;
        end else if (ce) begin
            unique case (state)
                CLEAR: begin
                    clr_adr <= clr_adr + ADDR_W'(1);
                    if (clr_adr == '1) begin
                        clr_adr  <= '0;
                        mem_busy <= 1'b0;
                        state    <= boot ? LOADER_OWN : GUARD;
                    end
                end
                LOADER_OWN: if (!boot) state <= GUARD;
                GUARD:      state <= boot ? LOADER_OWN : CPU_OWN;
                CPU_OWN:    if (boot) state <= GUARD;
                default:    state <= CLEAR;
            endcase
        end
    end

    // The RAM has one read register; *_sel marks whose data it currently holds,
    // and the other master's last word is parked in its hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ack     <= 1'b0;
            drop_err    <= 1'b0;
            ld_wr_count <= '0;
            ld_sel      <= 1'b0;
            cpu_sel     <= 1'b0;
            ld_hold     <= '0;
            cpu_hold    <= '0;
        end else begin
            cpu_ack <= cpu_acc;
            if (ce) begin
                if (ld_drop) drop_err <= 1'b1;
                if (ld_wr && (ld_wr_count != FULL_CNT))
                    ld_wr_count <= ld_wr_count + (ADDR_W+1)'(1);
                if (ld_sel)  ld_hold  <= ram_dout;
                if (cpu_sel) cpu_hold <= ram_dout;
                if (ld_rd) begin
                    ld_sel  <= 1'b1;
                    cpu_sel <= 1'b0;
                end else if (cpu_rd) begin
                    cpu_sel <= 1'b1;
                    ld_sel  <= 1'b0;
                end
            end
        end
    end

    assign ld_out  = ld_sel  ? ram_dout : ld_hold;
    assign cpu_out = cpu_sel ? ram_dout : cpu_hold;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Scoreboard bench for boot_mem_arbiter: directed scenarios plus random traffic vs. a word-array model.
module tb_boot_mem_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b1, boot = 1'b1;
    logic          ld_enable = 1'b0, ld_rw = 1'b0;
    logic [AW-1:0] ld_adr = '0;
    logic [DW-1:0] ld_in = '0;
    logic [DW-1:0] ld_out;
    logic          cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [AW-1:0] cpu_adr = '0;
    logic [DW-1:0] cpu_in = '0;
    logic [DW-1:0] cpu_out;
    logic          cpu_ack, cpu_wait, mem_busy, drop_err;
    logic [AW:0]   ld_wr_count;

    boot_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .boot(boot),
        .ld_enable(ld_enable), .ld_rw(ld_rw), .ld_adr(ld_adr), .ld_in(ld_in), .ld_out(ld_out),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adr(cpu_adr), .cpu_in(cpu_in), .cpu_out(cpu_out),
        .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .mem_busy(mem_busy), .drop_err(drop_err),
        .ld_wr_count(ld_wr_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = clearing, 1 = loader owns, 2 = handover gap, 3 = CPU owns.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_phase, m_clr, m_cnt;
    bit            m_drop;
    logic [DW-1:0] m_ld_out, m_cpu_out;
    bit            exp_ack = 1'b0;
    logic [DW-1:0] ld_q[$];
    logic [DW-1:0] cpu_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented read result against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
            if (cpu_ack && cpu_q.size() > 0) check("cpu_out@ack", 32'(cpu_out), 32'(cpu_q.pop_front()));
            while (ld_q.size() > 0) check("ld_out@read", 32'(ld_out), 32'(ld_q.pop_front()));
        end
    end

    task automatic step();
        bit acc;
        #1;
        check("mem_busy", 32'(mem_busy), 32'(m_phase == 0));
        check("cpu_wait", 32'(cpu_wait), 32'(cpu_req && m_phase != 3));
        @(posedge clk);
        acc = 1'b0;
        if (ce) begin
            if (ld_enable && ld_rw && m_phase != 1) m_drop = 1'b1;
            case (m_phase)
                0: begin
                    m_mem[m_clr] = '0;
                    m_clr++;
                    if (m_clr == DEPTH) m_phase = boot ? 1 : 2;
                end
                1: begin
                    if (ld_enable) begin
                        if (ld_rw) begin
                            m_mem[ld_adr] = ld_in;
                            if (m_cnt < DEPTH) m_cnt++;
                        end else begin
                            m_ld_out = m_mem[ld_adr];
                            ld_q.push_back(m_ld_out);
                        end
                    end
                    if (!boot) m_phase = 2;
                end
                2: m_phase = boot ? 1 : 3;
                default: begin
                    if (cpu_req) begin
                        if (cpu_rw) m_mem[cpu_adr] = cpu_in;
                        else        m_cpu_out = m_mem[cpu_adr];
                        cpu_q.push_back(m_cpu_out);
                        acc = 1'b1;
                    end
                    if (boot) m_phase = 2;
                end
            endcase
        end
        exp_ack = acc;
        #1;
        check("drop_err", 32'(drop_err), 32'(m_drop));
        check("ld_wr_count", 32'(ld_wr_count), 32'(m_cnt));
        check("ld_out_hold", 32'(ld_out), 32'(m_ld_out));
        check("cpu_out_hold", 32'(cpu_out), 32'(m_cpu_out));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_enable = 1'b0;
        cpu_req = 1'b0;
        exp_ack = 1'b0;
        ld_q.delete();
        cpu_q.delete();
        #1;
        check("rst_ld_out", 32'(ld_out), 32'd0);
        check("rst_cpu_out", 32'(cpu_out), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_wr_count", 32'(ld_wr_count), 32'd0);
        check("rst_mem_busy", 32'(mem_busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_phase = 0; m_clr = 0; m_cnt = 0; m_drop = 1'b0;
        m_ld_out = '0; m_cpu_out = '0;
    endtask

    task automatic ld_op(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_enable = 1'b1; ld_rw = rw; ld_adr = a; ld_in = d;
        step();
    endtask

    initial begin
        #1;
        // Clear sweep then full read-back of zeros.
        ce = 1'b1; boot = 1'b1;
        do_reset();
        repeat (DEPTH) step();
        for (int i = 0; i < DEPTH; i++) ld_op(1'b0, AW'(i), '0);

        // Loader writes, read latency, write-count saturation.
        ld_op(1'b1, 6'd0, 16'hA5A5);
        ld_op(1'b1, 6'd63, 16'h1234);
        ld_op(1'b0, 6'd63, '0);
        for (int a = 1; a < 63; a++) ld_op(1'b1, AW'(a), DW'($urandom));
        for (int a = 1; a < 4; a++)  ld_op(1'b1, AW'(a), DW'($urandom));
        ld_op(1'b0, 6'd0, '0);

        // Handover through GUARD; CPU request waits, then is served.
        ld_enable = 1'b1; ld_rw = 1'b0;
        boot = 1'b0;
        step();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_adr = 6'd0;
        step();
        step();
        cpu_req = 1'b0;
        step();

        // Loader write while CPU owns: dropped, sticky error.
        ld_enable = 1'b1; ld_rw = 1'b1; ld_adr = 6'd0; ld_in = 16'hFFFF;
        step();
        ld_enable = 1'b0;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_adr = 6'd0;
        step();
        cpu_req = 1'b0;
        step();

        // Clock-enable gating of a CPU read.
        cpu_req = 1'b1; cpu_adr = 6'd63;
        ce = 1'b0; step(); step();
        ce = 1'b1; step();
        cpu_req = 1'b0; ce = 1'b0; step();
        ce = 1'b1; step();

        // Reset in the middle of the clear sweep; dropped write during CLEAR.
        boot = 1'b1;
        do_reset();
        repeat (30) step();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) begin
                ld_enable = 1'b1; ld_rw = 1'b1; ld_adr = 6'd5; ld_in = 16'hBEEF;
            end else begin
                ld_enable = 1'b0;
            end
            step();
        end
        ld_op(1'b0, 6'd5, '0);

        // Random traffic with ownership changes and ce stalls.
        for (int n = 0; n < 3000; n++) begin
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) boot = ~boot;
            ld_enable = 1'($urandom_range(0, 1));
            ld_rw     = ($urandom_range(0, 2) == 0);
            ld_adr    = AW'($urandom);
            ld_in     = DW'($urandom);
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1;
                cpu_rw  = 1'($urandom_range(0, 1));
                cpu_adr = AW'($urandom);
                cpu_in  = DW'($urandom);
            end
            step();
            if (exp_ack) cpu_req = 1'b0;
        end

        ld_enable = 1'b0; cpu_req = 1'b0; ce = 1'b1;
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
